// File: rtl/hamming_secded_stream.sv
// Two-stage streaming Hamming SECDED decoder with valid/ready flow control
// and saturating single/double error-event counters.
module hamming_secded_stream #(
  parameter int DATA_W = 6,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16,
  localparam int CW_W  = DATA_W + PAR_W + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CW_W-1:0]   IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              DETECT_ONLY,
  input  logic              CNT_CLR,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [PAR_W-1:0]  OUT_SYNDROME,
  output logic              OUT_SINGLE,
  output logic              OUT_DOUBLE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  SINGLE_CNT,
  output logic [CNT_W-1:0]  DOUBLE_CNT
);

  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CW_W - 1);

  function automatic logic [PAR_W-1:0] calc_syn(input logic [CW_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int k = 0; k < PAR_W; k++)
      for (int i = 1; i < CW_W; i++)
        if (((i >> k) & 1) == 1) s[k] = s[k] ^ cw[i];
    return s;
  endfunction

  // Payload sits at every non-power-of-two position, lowest first.
  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW_W; i++)
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    return d;
  endfunction

  logic              adv;
  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_det;

  logic              oor;
  logic [CW_W-1:0]   fix_cw;
  logic              d_single;
  logic              d_double;
  logic              xfer;

  assign adv      = ~OUT_VALID | OUT_READY;
  assign IN_READY = adv;
  assign xfer     = OUT_VALID & OUT_READY;

  always_comb begin
    oor      = s1_syn > MAX_POS;
    fix_cw   = s1_cw;
    d_single = s1_par & ~oor;
    d_double = (~s1_par & (|s1_syn)) | (s1_par & oor);
    if (s1_par && (|s1_syn) && !oor && !s1_det)
      fix_cw[s1_syn] = ~s1_cw[s1_syn];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid     <= 1'b0;
      s1_cw        <= '0;
      s1_syn       <= '0;
      s1_par       <= 1'b0;
      s1_det       <= 1'b0;
      OUT_VALID    <= 1'b0;
      OUT_DATA     <= '0;
      OUT_SYNDROME <= '0;
      OUT_SINGLE   <= 1'b0;
      OUT_DOUBLE   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= IN_VALID;
      OUT_VALID <= s1_valid;
      if (IN_VALID) begin
        s1_cw  <= IN_DATA;
        s1_syn <= calc_syn(IN_DATA);
        s1_par <= ^IN_DATA;
        s1_det <= DETECT_ONLY;
      end
      if (s1_valid) begin
        OUT_DATA     <= extract(fix_cw);
        OUT_SYNDROME <= s1_syn;
        OUT_SINGLE   <= d_single;
        OUT_DOUBLE   <= d_double;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      SINGLE_CNT <= '0;
      DOUBLE_CNT <= '0;
    end else begin
      if (xfer && OUT_SINGLE && !(&SINGLE_CNT))
        SINGLE_CNT <= SINGLE_CNT + 1'b1;
      if (xfer && OUT_DOUBLE && !(&DOUBLE_CNT))
        DOUBLE_CNT <= DOUBLE_CNT + 1'b1;
    end
  end

endmodule

// File: doc/hamming_secded_stream.md
HAMMING_SECDED_STREAM -- requirements
Module: hamming_secded_stream

Interface
REQ-001 Parameter DATA_W, default 6, number of payload bits per codeword.
REQ-002 Parameter PAR_W, default 4, number of Hamming check bits; legal only if 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 Parameter CNT_W, default 16, width of each error-event counter.
REQ-004 Derived CW_W = DATA_W+PAR_W+1: bit 0 is overall even parity; bits 1..CW_W-1 are Hamming positions, with check bits at powers of two and payload at the other positions in ascending order (OUT_DATA[0] = lowest payload position).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- IN_DATA  in  CW_W  received codeword.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  block accepts IN_DATA this cycle.
- DETECT_ONLY  in  1  1 = flag errors but never correct; sampled with IN_DATA.
- CNT_CLR  in  1  clear both counters.
- OUT_DATA  out  DATA_W  decoded payload.
- OUT_SYNDROME  out  PAR_W  Hamming syndrome of the codeword.
- OUT_SINGLE  out  1  correctable single error.
- OUT_DOUBLE  out  1  uncorrectable error.
- OUT_VALID  out  1  outputs valid.
- OUT_READY  in  1  downstream accepts outputs.
- SINGLE_CNT  out  CNT_W  saturating count of transferred OUT_SINGLE words.
- DOUBLE_CNT  out  CNT_W  saturating count of transferred OUT_DOUBLE words.

Function
REQ-007 Input transfer occurs when IN_VALID & IN_READY; output transfer occurs when OUT_VALID & OUT_READY.
REQ-008 The pipeline SHALL have two register stages. Stage 1 registers the codeword, syndrome S, overall parity P and mode. Stage 2 registers corrected data and flags. Latency from input transfer to OUT_VALID is 2 cycles when not stalled.
REQ-009 Advance enable ADV = ~OUT_VALID | OUT_READY. IN_READY = ADV (combinational). While ADV=0, both stages hold their contents, and stage-1 data is never lost or duplicated.
REQ-010 Stage-1 valid loads IN_VALID on ADV. Stage-2 valid (OUT_VALID) loads stage-1 valid on ADV. Bubbles propagate as OUT_VALID=0.
REQ-011 Bit S[k] SHALL be the XOR of all positions i in 1..CW_W-1 with bit k of i set; P SHALL be the XOR of all CW_W bits.
REQ-012 Classification:
- S=0, P=0: clean; SINGLE=0, DOUBLE=0.
- P=1, 1<=S<=CW_W-1: SINGLE=1; position S is flipped before extraction unless DETECT_ONLY=1.
- P=1, S=0: SINGLE=1; the error is in the parity bit, payload is unchanged.
- P=0, S!=0: DOUBLE=1.
- P=1, S>CW_W-1: DOUBLE=1.
REQ-013 On DOUBLE, OUT_DATA SHALL be the raw, uncorrected payload (never Z/X). SINGLE and DOUBLE are mutually exclusive.
REQ-014 OUT_SYNDROME = S in every case, including clean (0).
REQ-015 The counters SHALL increment by 1 only on an output transfer carrying the matching flag, and saturate at 2^CNT_W-1.
REQ-016 When CNT_CLR is asserted in a cycle, both counters SHALL be 0 next cycle; clear wins over a simultaneous increment, and a counter at saturation stays saturated until cleared.
REQ-017 Each output SHALL stay stable while OUT_VALID=1 and OUT_READY=0.

Reset
REQ-018 On RST=1 at a clock edge: both stage valids, OUT_VALID, OUT_DATA, OUT_SYNDROME, OUT_SINGLE, OUT_DOUBLE, SINGLE_CNT and DOUBLE_CNT SHALL be 0.
REQ-019 RST mid-stream SHALL discard any in-flight words with no output transfer and no count. IN_READY SHALL be 1 in the first cycle after reset.

Verification (defaults DATA_W=6, PAR_W=4, CW_W=11)
REQ-020 Clean word: IN_DATA=11'h6F9, OUT_READY=1 -> two cycles later OUT_DATA=6'h3F, SYNDROME=0, SINGLE=0, DOUBLE=0; counters unchanged.
REQ-021 Single error: IN_DATA=11'h020 (all-zero word, bit 5 flipped) -> OUT_DATA=0, SYNDROME=5, SINGLE=1, SINGLE_CNT=1. Same input with DETECT_ONLY=1 -> OUT_DATA=6'h02, SINGLE=1.
REQ-022 Double and out-of-range errors:
- IN_DATA=11'h028 -> SYNDROME=6, DOUBLE=1, OUT_DATA=6'h03, DOUBLE_CNT=1.
- IN_DATA=11'h111 -> SYNDROME=12, DOUBLE=1.
REQ-023 Backpressure: stream of 4 words with OUT_READY=0 for 5 cycles mid-stream -> IN_READY=0 while stalled; all 4 outputs appear in order, with no loss or duplication.
REQ-024 Saturation/clear: CNT_W forced to 2, 5 single-error transfers -> SINGLE_CNT=3. CNT_CLR asserted in the same cycle as a single-error transfer -> SINGLE_CNT=0.
REQ-025 Reset mid-stream: RST asserted with 2 words in flight -> OUT_VALID=0, counters 0, no output transfer of those words.
